// File: rtl/nand_test_sequencer.sv
// -----------------------------------------------------------------------------
// nand_test_sequencer
//
// In-system exerciser for a two-input NAND gate. During a run it owns the
// gate's A/B inputs, walks them through the combinations 00, 01, 10, 11,
// holds each one for SETTLE_CYCLES, samples the gate output and compares it
// with the NAND truth table. PASSES complete sweeps make up one run.
// Failures are collected into a sticky per-combination mask and a saturating
// count, and a start/done handshake reports the result to the surrounding
// test logic.
//
// Parameters
//   SETTLE_CYCLES  hold time per combination before sampling (1..255)
//   PASSES         full four-combination sweeps per run        (1..255)
//
// Ports
//   clk         in   clock, rising-edge
//   rst_n       in   asynchronous active-low reset
//   start       in   single-cycle run request, honoured only when idle
//   abort       in   terminate the run, honoured in any state
//   gate_o      in   output of the NAND gate under test
//   drv_a       out  drives gate input A
//   drv_b       out  drives gate input B
//   cur_combo   out  combination index currently driven, {drv_a,drv_b}
//   busy        out  run in progress
//   done        out  one-cycle completion pulse
//   pass        out  last completed run had zero failures
//   fail_mask   out  sticky per-combination failure flags
//   fail_count  out  failing samples, saturating at 255
// -----------------------------------------------------------------------------
module nand_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_o,
  output logic       drv_a,
  output logic       drv_b,
  output logic [1:0] cur_combo,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] fail_count
);

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_PASS     = 8'(PASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [7:0] r_settle_cnt;
  logic [7:0] r_pass_cnt;
  logic [1:0] r_combo;
  logic [3:0] r_fail_mask;
  logic [7:0] r_fail_count;
  logic       r_pass;

  logic       w_start;
  logic       w_expected;
  logic       w_mismatch;
  logic       w_last_sample;

  assign w_start       = start & ~abort & (r_state == ST_IDLE);
  assign w_expected    = ~(r_combo[1] & r_combo[0]);
  assign w_mismatch    = gate_o ^ w_expected;
  assign w_last_sample = (r_combo == 2'd3) && (r_pass_cnt == LAST_PASS);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. abort overrides everything, including a start in IDLE.
  // NOTE: the default assignment at the top keeps this block free of
  // inferred latches on paths that do not assign w_state_next.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_state_next = ST_SETTLE;
        ST_SETTLE: if (r_settle_cnt == 8'd0) w_state_next = ST_SAMPLE;
        ST_SAMPLE: w_state_next = w_last_sample ? ST_DONE : ST_SETTLE;
        ST_DONE:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode. Outside SETTLE/SAMPLE the gate inputs are parked at 0,
  // which also covers DONE, abort and reset.
  always_comb begin
    busy  = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    done  = (r_state == ST_DONE);
    drv_a = busy & r_combo[1];
    drv_b = busy & r_combo[0];
  end

  assign cur_combo  = r_combo;
  assign pass       = r_pass;
  assign fail_mask  = r_fail_mask;
  assign fail_count = r_fail_count;

  // Sequencing counters and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_pass_cnt   <= '0;
      r_combo      <= '0;
      r_fail_mask  <= '0;
      r_fail_count <= '0;
      r_pass       <= 1'b0;
    end else if (abort) begin
      // Partial mask/count are kept for diagnosis; only the verdict drops.
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_fail_mask  <= '0;
            r_fail_count <= '0;
            r_pass       <= 1'b0;
            r_combo      <= 2'd0;
            r_pass_cnt   <= 8'd0;
            r_settle_cnt <= SETTLE_RELOAD;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt != 8'd0) r_settle_cnt <= r_settle_cnt - 8'd1;
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            r_fail_mask[r_combo] <= 1'b1;
            if (r_fail_count != 8'hFF) r_fail_count <= r_fail_count + 8'd1;
          end
          if (w_last_sample) begin
            // Verdict must include the sample being taken on this edge.
            r_pass <= ~w_mismatch & (r_fail_count == 8'd0);
          end else begin
            r_combo      <= r_combo + 2'd1;
            r_settle_cnt <= SETTLE_RELOAD;
            if (r_combo == 2'd3) r_pass_cnt <= r_pass_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nand_test_sequencer
//
// Two sequencer instances: u_dut with default parameters driving a NAND model
// with programmable per-combination faults, and u_sat (SETTLE_CYCLES=1,
// PASSES=100) driving a stuck-at-0 gate to exercise count saturation.
// Expected results come from the timing rules (combination k is driven from
// cycle k*(SETTLE_CYCLES+1)) and from fault counting over whole sweeps.
// -----------------------------------------------------------------------------
module tb_nand_test_sequencer;

  localparam int S_A = 2;
  localparam int P_A = 2;
  localparam int T_A = 4 * P_A * (S_A + 1);
  localparam int S_S = 1;
  localparam int P_S = 100;
  localparam int T_S = 4 * P_S * (S_S + 1);

  logic       clk;
  logic       rst_n;

  logic       start_a, abort_a, gate_a;
  logic       drv_a_a, drv_b_a, busy_a, done_a, pass_a;
  logic [1:0] combo_a;
  logic [3:0] mask_a;
  logic [7:0] count_a;
  logic [3:0] fault_a;

  logic       start_s, abort_s, gate_s;
  logic       drv_a_s, drv_b_s, busy_s, done_s, pass_s;
  logic [1:0] combo_s;
  logic [3:0] mask_s;
  logic [7:0] count_s;

  int n_checks;
  int n_errors;

  // Gate under test: true NAND, inverted on combinations flagged in fault_a.
  assign gate_a = (~(drv_a_a & drv_b_a)) ^ fault_a[{drv_a_a, drv_b_a}];
  assign gate_s = 1'b0;

  nand_test_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .gate_o(gate_a), .drv_a(drv_a_a), .drv_b(drv_b_a), .cur_combo(combo_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(mask_a),
    .fail_count(count_a)
  );

  nand_test_sequencer #(.SETTLE_CYCLES(S_S), .PASSES(P_S)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
    .gate_o(gate_s), .drv_a(drv_a_s), .drv_b(drv_b_s), .cur_combo(combo_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_mask(mask_s),
    .fail_count(count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero_a(input string tag);
    check({tag, "_drv_a"}, drv_a_a, 0);
    check({tag, "_drv_b"}, drv_b_a, 0);
    check({tag, "_combo"}, combo_a, 0);
    check({tag, "_busy"},  busy_a,  0);
    check({tag, "_done"},  done_a,  0);
    check({tag, "_pass"},  pass_a,  0);
    check({tag, "_mask"},  mask_a,  0);
    check({tag, "_count"}, count_a, 0);
  endtask

  // One run on u_dut. abort_at / extra_start_at / reset_at are cycle numbers
  // relative to the start edge (0 disables). Expected mask/count are derived
  // from which sample edges (j+1)*(S+1) happen before the run is cut short.
  task automatic run_a(input logic [3:0] f, input int abort_at,
                       input int extra_start_at, input int reset_at);
    logic [3:0] m;
    int         c;
    int         stop_n;
    int         k;
    m = '0;
    c = 0;
    fault_a = f;
    for (int j = 0; j < 4 * P_A; j++) begin
      if (abort_at == 0 || (j + 1) * (S_A + 1) < abort_at) begin
        if (f[j % 4]) begin
          m[j % 4] = 1'b1;
          c++;
        end
      end
    end
    if (c > 255) c = 255;
    if (abort_at > 0)      stop_n = abort_at + 3;
    else if (reset_at > 0) stop_n = reset_at;
    else                   stop_n = T_A + 1;

    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int n = 0; n <= stop_n; n++) begin
      if (reset_at > 0 && n == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero_a("reset_midrun");
        return;
      end
      if (abort_at > 0 && n >= abort_at) begin
        check("abort_busy",  busy_a,  0);
        check("abort_drv_a", drv_a_a, 0);
        check("abort_drv_b", drv_b_a, 0);
        check("abort_done",  done_a,  0);
        check("abort_pass",  pass_a,  0);
        check("abort_mask",  mask_a,  m);
        check("abort_count", count_a, c);
      end else if (n < T_A) begin
        k = (n / (S_A + 1)) % 4;
        check("run_busy",  busy_a,  1);
        check("run_done",  done_a,  0);
        check("run_combo", combo_a, k);
        check("run_drv_a", drv_a_a, (k >> 1) & 1);
        check("run_drv_b", drv_b_a, k & 1);
      end else if (n == T_A) begin
        check("done_pulse", done_a,  1);
        check("done_busy",  busy_a,  0);
        check("done_drv_a", drv_a_a, 0);
        check("done_drv_b", drv_b_a, 0);
        check("done_pass",  pass_a,  (m == 4'd0));
        check("done_mask",  mask_a,  m);
        check("done_count", count_a, c);
      end else begin
        check("after_done", done_a, 0);
        check("after_busy", busy_a, 0);
        check("after_pass", pass_a, (m == 4'd0));
        check("after_mask", mask_a, m);
        check("after_count", count_a, c);
      end
      start_a = (n + 1 == extra_start_at);
      abort_a = (n + 1 == abort_at);
      @(posedge clk);
      #1;
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  initial begin
    int         n;
    logic [3:0] f;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start_a  = 1'b0;
    abort_a  = 1'b0;
    start_s  = 1'b0;
    abort_s  = 1'b0;
    fault_a  = 4'd0;

    #12;
    check_all_zero_a("reset");
    check("reset_sat_busy",  busy_s,  0);
    check("reset_sat_count", count_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Healthy gate, with an ignored extra start at cycle 5.
    run_a(4'b0000, 0, 5, 0);
    // Stuck-at-1: only combination 3 (expected 0) fails, once per pass.
    run_a(4'b1000, 0, 0, 0);
    // Random fault patterns.
    repeat (4) begin
      f = 4'($urandom_range(0, 15));
      run_a(f, 0, 0, 0);
    end
    // Abort at cycle 10 on a healthy gate, then a clean restart.
    run_a(4'b0000, 10, 0, 0);
    run_a(4'b0000, 0, 0, 0);
    // Abort at a random cycle with a random fault pattern: partial results hold.
    f = 4'($urandom_range(1, 15));
    run_a(f, int'($urandom_range(2, T_A - 1)), 0, 0);
    run_a(4'b0000, 0, 0, 0);

    // start and abort together in IDLE: stays idle, verdict cleared.
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    abort_a = 1'b0;
    check("start_abort_busy", busy_a, 0);
    check("start_abort_done", done_a, 0);
    check("start_abort_pass", pass_a, 0);
    @(posedge clk);
    #1;
    check("start_abort_busy2", busy_a, 0);

    // Reset at cycle 7 of a run, then a full run.
    run_a(4'b0000, 0, 0, 7);
    #3;
    rst_n = 1'b1;
    run_a(4'b0000, 0, 0, 0);

    // Saturation: stuck-at-0, 100 passes, settle 1.
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    n = 0;
    while (!done_s && n < 2 * T_S) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sat_done_time", n, T_S);
    check("sat_done",  done_s,  1);
    check("sat_busy",  busy_s,  0);
    check("sat_mask",  mask_s,  4'b0111);
    check("sat_count", count_s, (3 * P_S > 255) ? 255 : 3 * P_S);
    check("sat_pass",  pass_s,  0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
